// File: rtl/spi_cmd_seq.sv
// SPI register-access sequencer: queues a command/data byte pair into a TX FIFO,
// drains the echoed reply pair from an RX FIFO and returns the read byte.
module spi_cmd_seq #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RW,
  input  logic [6:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] RDATA,
  input  logic       TX_FULL,
  output logic       TX_WR,
  output logic [7:0] TX_DIN,
  input  logic       RX_EMPTY,
  output logic       RX_RD,
  input  logic [7:0] RX_DOUT
);

  typedef enum logic [3:0] {
    IDLE, TX_CMD, TX_DAT, RX_WAIT0, RX_POP0, RX_WAIT1, RX_POP1, RX_CAP, FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic             rw_q;
  logic [7:0]       dat_q;
  logic [CNT_W-1:0] cnt;

  // The write strobe tracks TX_FULL in the same cycle so a byte never lands on a full FIFO.
  assign TX_WR = ((state == TX_CMD) || (state == TX_DAT)) && !TX_FULL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      rw_q   <= 1'b0;
      dat_q  <= 8'h00;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      RDATA  <= 8'h00;
      TX_DIN <= 8'h00;
      RX_RD  <= 1'b0;
    end else begin
      // NOTE: non-blocking only; every branch below reads the pre-edge value of every register.
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      RX_RD <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            rw_q   <= RW;
            dat_q  <= RW ? 8'h00 : WDATA;
            TX_DIN <= {RW, ADDR};
            BUSY   <= 1'b1;
            state  <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (!TX_FULL) begin
            TX_DIN <= dat_q;
            state  <= TX_DAT;
          end
        end
        TX_DAT: begin
          if (!TX_FULL) begin
            cnt   <= '0;
            state <= RX_WAIT0;
          end
        end
        RX_WAIT0, RX_WAIT1: begin
          // Arriving data outranks a timeout that expires in the same cycle.
          if (!RX_EMPTY) begin
            RX_RD <= 1'b1;
            state <= (state == RX_WAIT0) ? RX_POP0 : RX_POP1;
          end else if (cnt == CNT_LAST) begin
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= FINISH;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_POP0: begin
          cnt   <= '0;
          state <= RX_WAIT1;
        end
        RX_POP1: state <= RX_CAP;
        RX_CAP: begin
          if (rw_q) RDATA <= RX_DOUT;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Randomized bench for spi_cmd_seq: FIFO environment plus a transaction-level
// reference model of the expected byte traffic, error flag, read data and latency.
module tb_spi_cmd_seq;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata, tx_din, rx_dout;
  logic       busy, done, err, tx_full, tx_wr, rx_empty, rx_rd;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] model_rdata = 8'h00;

  spi_cmd_seq #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .CLK(clk), .RST(rst), .START(start), .RW(rw), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .ERR(err), .RDATA(rdata),
    .TX_FULL(tx_full), .TX_WR(tx_wr), .TX_DIN(tx_din),
    .RX_EMPTY(rx_empty), .RX_RD(rx_rd), .RX_DOUT(rx_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_tx_wr"}, tx_wr, 1'b0);
    check({tag, "_rx_rd"}, rx_rd, 1'b0);
    check({tag, "_tx_din"}, tx_din, 8'h00);
    check({tag, "_rdata"}, rdata, 8'h00);
  endtask

  // k0/k1: cycles after entering the matching wait state before the reply byte shows up
  // (-1 = never). stall: TX_FULL held for that many cycles after START.
  task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] b0, input logic [7:0] b1, input int k0, input int k1,
                         input int stall, input bit rnd_full, input bit dup_start,
                         input int rst_after);
    logic [7:0] tx_log[$];
    logic [7:0] last = 8'h00;
    logic [7:0] tx0 = 8'hxx;
    logic [7:0] tx1 = 8'hxx;
    logic [7:0] got_rdata = 8'hxx;
    logic       got_err = 1'bx;
    int  n_rd = 0, n_done = 0, t2 = -1, p0 = -1, done_cyc = -1, vis0 = -1, vis1 = -1;
    bit  aborted = 0;
    bit  exp_to0 = (k0 < 0) || (k0 > TO - 1);
    bit  exp_to1 = !exp_to0 && ((k1 < 0) || (k1 > TO - 1));
    int  exp_rd = exp_to0 ? 0 : (exp_to1 ? 1 : 2);

    for (int c = 0; c < 400 && n_done == 0 && !aborted; c++) begin
      @(posedge clk); #1;
      rst   = 1'b0;
      start = (c == 0) || (dup_start && c == 3);
      if (c == 0) begin
        rw = t_rw; addr = t_addr; wdata = t_wdata;
      end else if (dup_start && c == 3) begin
        rw = ~t_rw; addr = ~t_addr; wdata = ~t_wdata;
      end
      tx_full  = (c >= 1 && c <= stall) || (rnd_full && $urandom_range(0, 3) == 0);
      rx_empty = !((n_rd == 0 && vis0 >= 0 && c >= vis0) || (n_rd == 1 && vis1 >= 0 && c >= vis1));
      rx_dout  = last;
      #4;
      if (c == 1) check("busy_rise", busy, 1'b1);
      check("tx_wr_gate", tx_wr & tx_full, 1'b0);
      check("rx_rd_gate", rx_rd & rx_empty, 1'b0);
      if (tx_wr) begin
        tx_log.push_back(tx_din);
        if (tx_log.size() == 2) begin
          t2   = c;
          vis0 = (k0 < 0) ? -1 : c + 1 + k0;
        end
      end
      if (rx_rd) begin
        n_rd++;
        last = (n_rd == 1) ? b0 : b1;
        if (n_rd == 1) begin
          p0   = c;
          vis1 = (k1 < 0) ? -1 : c + 1 + k1;
        end
      end
      if (done) begin
        n_done++;
        done_cyc  = c;
        got_err   = err;
        got_rdata = rdata;
        check("busy_fall", busy, 1'b0);
      end
      if (rst_after >= 0 && p0 >= 0 && c == p0 + rst_after) aborted = 1;
    end

    if (aborted) begin
      check("abort_no_done", n_done, 0);
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; tx_full = 1'b0; rx_empty = 1'b1;
      #4;
      check_reset_outputs("mid_rst");
      @(posedge clk); #5;
      check("mid_rst_done_hold", done, 1'b0);
      model_rdata = 8'h00;
      return;
    end

    if (tx_log.size() > 0) tx0 = tx_log[0];
    if (tx_log.size() > 1) tx1 = tx_log[1];
    check("done_seen", n_done, 1);
    check("tx_count", tx_log.size(), 2);
    check("tx_cmd_byte", tx0, {t_rw, t_addr});
    check("tx_dat_byte", tx1, t_rw ? 8'h00 : t_wdata);
    check("rx_rd_count", n_rd, exp_rd);
    check("err", got_err, exp_to0 || exp_to1);
    if (t_rw && !exp_to0 && !exp_to1) model_rdata = b1;
    check("rdata", got_rdata, model_rdata);
    if (stall == 0 && !rnd_full && k0 == 0 && k1 == 0) check("min_latency", done_cyc, 8);
    if (exp_to0) check("timeout0_latency", done_cyc - (t2 + 1), TO);
    if (exp_to1) check("timeout1_latency", done_cyc - (p0 + 1), TO);

    @(posedge clk); #1;
    start = 1'b0; tx_full = 1'b0; rx_empty = 1'b1;
    #4;
    check("done_single", done, 1'b0);
    check("rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    tx_full = 1'b0; rx_empty = 1'b1; rx_dout = 8'h00;
    repeat (3) @(posedge clk);
    #5;
    check_reset_outputs("reset");

    // write, read, backpressure
    run_txn(1'b0, 7'h12, 8'hA5, 8'h5A, 8'hC3, 0, 0, 0, 0, 0, -1);
    run_txn(1'b1, 7'h05, 8'h00, 8'hFF, 8'h3C, 0, 0, 0, 0, 0, -1);
    run_txn(1'b0, 7'h33, 8'h96, 8'h11, 8'h22, 0, 0, 20, 0, 0, -1);
    // timeout in first wait, then the data-wins boundary and one past it
    run_txn(1'b1, 7'h44, 8'h00, 8'h01, 8'h02, -1, 0, 0, 0, 0, -1);
    run_txn(1'b1, 7'h45, 8'h00, 8'h03, 8'h7E, TO - 1, TO - 1, 0, 0, 0, -1);
    run_txn(1'b1, 7'h46, 8'h00, 8'h04, 8'h05, TO, 0, 0, 0, 0, -1);
    run_txn(1'b1, 7'h47, 8'h00, 8'h06, 8'h07, 0, -1, 0, 0, 0, -1);
    // second START while busy is ignored
    run_txn(1'b0, 7'h21, 8'h5C, 8'h00, 8'h00, 0, 0, 0, 0, 1, -1);
    // reset in the second wait, then a read straight out of reset
    run_txn(1'b1, 7'h50, 8'h00, 8'hAA, 8'hBB, 0, -1, 0, 0, 0, 3);
    run_txn(1'b1, 7'h51, 8'h00, 8'h9C, 8'hD2, 0, 0, 0, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      int r0, r1, kk0, kk1;
      r0  = int'($urandom_range(0, 9));
      r1  = int'($urandom_range(0, 9));
      kk0 = (r0 == 0) ? -1 : (r0 == 1) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, TO - 1));
      kk1 = (r1 == 0) ? -1 : (r1 == 1) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, TO - 1));
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              kk0, kk1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_seq.md
SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT_CYC, default 4096, cycles allowed per RX byte wait before abort.
- CNT_W, default 13, width of the timeout counter; SHALL hold TIMEOUT_CYC.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  single system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request pulse; accepted only in IDLE.
- RW  in  1  1 = read access, 0 = write access; sampled with START.
- ADDR  in  7  register address; sampled with START.
- WDATA  in  8  write data; sampled with START.
- BUSY  out  1  high from the accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = timeout abort.
- RDATA  out  8  read result; valid from DONE until the next accepted START.
- TX_FULL  in  1  TX FIFO full flag.
- TX_WR  out  1  TX FIFO write strobe, one cycle per byte.
- TX_DIN  out  8  byte written to the TX FIFO.
- RX_EMPTY  in  1  RX FIFO empty flag.
- RX_RD  out  1  RX FIFO read strobe, one cycle per byte.
- RX_DOUT  in  8  RX FIFO data; valid the cycle after RX_RD.

REQ-003 The block SHALL have one clock, CLK, and one reset, RST, which is asynchronous and active-high.

Function
REQ-004 A START seen in IDLE SHALL latch RW, ADDR and WDATA. BUSY SHALL rise on the next cycle. START while BUSY SHALL be ignored.

REQ-005 The state machine SHALL have these states: IDLE, TX_CMD, TX_DAT, RX_WAIT0, RX_POP0, RX_WAIT1, RX_POP1, RX_CAP, FINISH.

REQ-006 In TX_CMD the block SHALL drive TX_DIN = {RW,ADDR}. It SHALL pulse TX_WR only in a cycle where TX_FULL=0, then go to TX_DAT. While TX_FULL=1 it SHALL hold TX_WR=0 and stay in TX_CMD.

REQ-007 In TX_DAT the block SHALL drive TX_DIN = WDATA for a write or 8'h00 for a read. It SHALL obey the same TX_FULL rule as REQ-006, then go to RX_WAIT0.

REQ-008 RX_WAIT0 and RX_WAIT1 SHALL each wait for RX_EMPTY=0, then go to the matching POP state. The timeout counter SHALL clear on entry to each wait state.

REQ-009 RX_POP0 SHALL pulse RX_RD and discard the byte (command-phase echo), then go to RX_WAIT1. RX_POP1 SHALL pulse RX_RD and go to RX_CAP.

REQ-010 In RX_CAP the block SHALL register RDATA <= RX_DOUT only when RW=1; for a write RDATA SHALL be left unchanged. It SHALL then go to FINISH.

REQ-011 In FINISH, DONE SHALL pulse for exactly one cycle with ERR=0 and the state SHALL return to IDLE. BUSY SHALL fall in the same cycle that DONE is high.

REQ-012 The timeout counter SHALL increment each cycle in a wait state while RX_EMPTY=1. When it reaches TIMEOUT_CYC-1, the state SHALL go to FINISH with ERR=1 and RDATA unchanged. The counter SHALL saturate, never wrap.

REQ-013 Each accepted access SHALL produce exactly two TX_WR pulses and at most two RX_RD pulses. RX_RD SHALL never assert while RX_EMPTY=1, and TX_WR SHALL never assert while TX_FULL=1.

REQ-014 Minimum latency from START to DONE, with the FIFOs never stalling and RX data already present, SHALL be 8 cycles.

REQ-015 If RX_EMPTY drops in the same cycle the counter reaches its limit, data SHALL take priority and there SHALL be no timeout.

Reset
REQ-016 While RST=1, state SHALL be IDLE and BUSY, DONE, ERR, TX_WR and RX_RD SHALL be 0. TX_DIN and RDATA SHALL be 8'h00 and the counter SHALL be 0.

REQ-017 RST asserted mid-access SHALL abort immediately with no DONE pulse. The block SHALL accept a START on the first cycle after RST releases.

Verification
REQ-018 Write: START, RW=0, ADDR=7'h12, WDATA=8'hA5 -> TX bytes 8'h12 then 8'hA5; two RX_RD pulses; DONE with ERR=0; RDATA unchanged.

REQ-019 Read: START, RW=1, ADDR=7'h05; RX bytes 8'hFF then 8'h3C -> TX bytes 8'h85, 8'h00; RDATA=8'h3C at DONE; ERR=0.

REQ-020 Backpressure: TX_FULL=1 for 20 cycles after START -> no TX_WR during the stall; both bytes written afterward in order.

REQ-021 Timeout: TIMEOUT_CYC=16 and RX_EMPTY held at 1 -> DONE with ERR=1 exactly 16 cycles after entering RX_WAIT0; zero RX_RD pulses.

REQ-022 Mid-access reset: RST pulsed while in RX_WAIT1 -> all outputs at reset values with no DONE; a new read START afterward completes normally.

REQ-023 Ignored START: a second START while BUSY -> only two TX_WR pulses in total; latched ADDR unchanged.
